switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 143 ++++++++++++++
 tb/tb_switch_debouncer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the board slide switches before they reach the combinational
// top-level. Each raw switch bit is brought into the clk domain through a
// two-flop synchronizer and then debounced independently. A new level is
// accepted only after the synchronized value has differed from the current
// clean level for DEBOUNCE_CYCLES consecutive clocks.
//
// Parameters:
//   WIDTH            number of switch bits conditioned
//   DEBOUNCE_CYCLES  consecutive mismatching clocks needed to accept a level
//                    (1 .. 2**CNT_W-1)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   sw_raw    raw switch pins, asynchronous to clk
//   sw_clean  debounced switch levels (feeds the downstream sw bus)
//   rise      one-cycle pulse per bit when sw_clean[i] goes 0->1
//   fall      one-cycle pulse per bit when sw_clean[i] goes 1->0
//   changed   OR of rise|fall, registered alongside the strobes
//   settled   1 when no bit has a pending debounce count
// ----------------------------------------------------------------------------
module switch_debouncer #(
   parameter int unsigned WIDTH           = 7,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_W           = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed,
   output logic             settled
);

   // Terminal count: reaching it on a mismatching edge accepts the new level.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronizer stages.
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   // Per-bit debounce state.
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0]            clean_q;
   logic [WIDTH-1:0]            clean_d;

   // Registered strobes and status.
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] fall_d;
   logic             changed_q;
   logic             changed_d;
   logic             settled_q;
   logic             settled_d;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer; nothing may sit between the stages.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
      end
   end

   // -------------------------------------------------------------------------
   // Debounce next-state. A bit counts while the synchronized level differs
   // from the clean level; any edge where they agree discards the count, so
   // a bounce back to the old level restarts the whole interval.
   // -------------------------------------------------------------------------
   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (sync2_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            clean_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
            // Direction follows the accepted level, so rise and fall are
            // mutually exclusive by construction.
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Status next-state: settled reflects the counters after this edge.
   // -------------------------------------------------------------------------
   always_comb begin
      settled_d = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (cnt_d[i] != '0) begin
            settled_d = 1'b0;
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   // -------------------------------------------------------------------------
   // Debounce state and registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         settled_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         settled_q <= settled_d;
      end
   end

   assign sw_clean = clean_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign changed  = changed_q;
   assign settled  = settled_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=7.
// The reference model works on the switch rules directly: the level seen by
// the debouncer is the raw value sampled two edges earlier, and a bit flips
// once that level has disagreed with the clean value on DEB consecutive
// edges.
// ----------------------------------------------------------------------------
module tb_switch_debouncer;

   localparam int W   = 7;
   localparam int DEB = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_clean;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         changed;
   logic         settled;

   int n_checks;
   int n_fails;

   // Reference model state.
   logic [W-1:0] hist[$];
   int           run[W];
   logic [W-1:0] m_clean;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_changed;
   logic         m_settled;

   switch_debouncer #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw),
      .sw_clean(sw_clean),
      .rise    (rise),
      .fall    (fall),
      .changed (changed),
      .settled (settled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < W; i++) run[i] = 0;
      m_clean   = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
      m_settled = 1'b1;
   endtask

   task automatic model_edge();
      logic [W-1:0] level;
      if (!rst_n) begin
         model_reset();
         return;
      end
      hist.push_back(sw_raw);
      if (hist.size() > 3) void'(hist.pop_front());
      level  = (hist.size() == 3) ? hist[0] : '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         if (level[i] != m_clean[i]) begin
            run[i]++;
            if (run[i] == DEB) begin
               m_clean[i] = level[i];
               if (level[i]) m_rise[i] = 1'b1;
               else          m_fall[i] = 1'b1;
               run[i] = 0;
            end
         end else begin
            run[i] = 0;
         end
      end
      m_changed = |(m_rise | m_fall);
      m_settled = 1'b1;
      for (int i = 0; i < W; i++) if (run[i] != 0) m_settled = 1'b0;
   endtask

   // Advance one clock, update the model, and step to the sampling point.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      sw_raw = 7'h7F;
      model_reset();
      #23;
      n_checks++;
      if ({sw_clean, rise, fall, changed, settled} !== {7'h00, 7'h00, 7'h00, 1'b0, 1'b1}) begin
         n_fails++;
         $display("FAIL reset_state: got clean=%h rise=%h fall=%h ch=%b st=%b, want 00 00 00 0 1",
                  sw_clean, rise, fall, changed, settled);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_checks++;
         if ({sw_clean, rise, fall, changed, settled} !==
             {m_clean, m_rise, m_fall, m_changed, m_settled}) begin
            n_fails++;
            $display("FAIL reset_release e%0d: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e,
                     sw_clean, rise, fall, changed, settled,
                     m_clean, m_rise, m_fall, m_changed, m_settled);
         end
         if (e == 4) begin
            n_checks++;
            if (settled !== 1'b0) begin
               n_fails++;
               $display("FAIL reset_counting_settled: got %b want 0", settled);
            end
         end
         if (e == 6) begin
            n_checks++;
            if ({sw_clean, rise, changed} !== {7'h7F, 7'h7F, 1'b1}) begin
               n_fails++;
               $display("FAIL reset_accept_e6: got clean=%h rise=%h ch=%b want 7f 7f 1",
                        sw_clean, rise, changed);
            end
         end
      end
   endtask

   // Drive a value and check the model over a fixed number of edges.
   task automatic drive_and_check(input logic [W-1:0] v, input int edges, input string name);
      sw_raw = v;
      for (int e = 1; e <= edges; e++) begin
         tick();
         n_checks++;
         if ({sw_clean, rise, fall, changed, settled} !==
             {m_clean, m_rise, m_fall, m_changed, m_settled}) begin
            n_fails++;
            $display("FAIL %s e%0d: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", name, e,
                     sw_clean, rise, fall, changed, settled,
                     m_clean, m_rise, m_fall, m_changed, m_settled);
         end
      end
   endtask

   task automatic test_clean_step();
      drive_and_check(7'h00, 8, "step_clear");
      sw_raw = 7'h01;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_checks++;
         if ({sw_clean, rise, fall, changed, settled} !==
             {m_clean, m_rise, m_fall, m_changed, m_settled}) begin
            n_fails++;
            $display("FAIL step e%0d: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e,
                     sw_clean, rise, fall, changed, settled,
                     m_clean, m_rise, m_fall, m_changed, m_settled);
         end
         n_checks++;
         if (e == 6 && {sw_clean, rise, settled} !== {7'h01, 7'h01, 1'b1}) begin
            n_fails++;
            $display("FAIL step_e6: got clean=%h rise=%h st=%b want 01 01 1",
                     sw_clean, rise, settled);
         end else if (e != 6 && rise !== 7'h00) begin
            n_fails++;
            $display("FAIL step_rise_width e%0d: got rise=%h want 00", e, rise);
         end
      end
   endtask

   task automatic test_bounce();
      drive_and_check(7'h00, 8, "bounce_clear");
      for (int k = 0; k < 4; k++) begin
         sw_raw = (k % 2 == 0) ? 7'h08 : 7'h00;
         for (int e = 0; e < 2; e++) begin
            tick();
            n_checks++;
            if ({sw_clean, rise, fall} !== {m_clean, m_rise, m_fall} || rise !== 7'h00) begin
               n_fails++;
               $display("FAIL bounce_quiet: got clean=%h rise=%h fall=%h want %h 00 00",
                        sw_clean, rise, fall, m_clean);
            end
         end
      end
      sw_raw = 7'h08;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_checks++;
         if ({sw_clean, rise, fall, changed, settled} !==
             {m_clean, m_rise, m_fall, m_changed, m_settled}) begin
            n_fails++;
            $display("FAIL bounce_hold e%0d: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e,
                     sw_clean, rise, fall, changed, settled,
                     m_clean, m_rise, m_fall, m_changed, m_settled);
         end
         if (e == 5 || e == 6) begin
            n_checks++;
            if (sw_clean[3] !== (e == 6)) begin
               n_fails++;
               $display("FAIL bounce_accept e%0d: got clean3=%b want %b", e, sw_clean[3],
                        (e == 6));
            end
         end
      end
   endtask

   task automatic test_glitch();
      drive_and_check(7'h00, 8, "glitch_clear");
      drive_and_check(7'h20, 3, "glitch_high");
      sw_raw = 7'h00;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_checks++;
         if ({sw_clean[5], rise, fall} !== {1'b0, 7'h00, 7'h00} || settled !== m_settled) begin
            n_fails++;
            $display("FAIL glitch e%0d: got clean5=%b rise=%h fall=%h st=%b want 0 00 00 %b",
                     e, sw_clean[5], rise, fall, settled, m_settled);
         end
      end
      n_checks++;
      if (settled !== 1'b1) begin
         n_fails++;
         $display("FAIL glitch_settled: got %b want 1", settled);
      end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] seen_rise;
      logic [W-1:0] seen_fall;
      int           n_changed;
      drive_and_check(7'h00, 8, "simul_clear");
      seen_rise = '0;
      n_changed = 0;
      sw_raw    = 7'h50;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (rise != 0) seen_rise = rise;
         if (changed) n_changed++;
      end
      n_checks++;
      if (seen_rise !== 7'h50 || n_changed != 1 || sw_clean !== 7'h50) begin
         n_fails++;
         $display("FAIL simul_rise: got rise=%h changed_pulses=%0d clean=%h want 50 1 50",
                  seen_rise, n_changed, sw_clean);
      end
      seen_fall = '0;
      n_changed = 0;
      sw_raw    = 7'h00;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (fall != 0) seen_fall = fall;
         if (changed) n_changed++;
      end
      n_checks++;
      if (seen_fall !== 7'h50 || n_changed != 1 || sw_clean !== 7'h00) begin
         n_fails++;
         $display("FAIL simul_fall: got fall=%h changed_pulses=%0d clean=%h want 50 1 00",
                  seen_fall, n_changed, sw_clean);
      end
   endtask

   task automatic test_async_reset();
      drive_and_check(7'h7F, 8, "areset_prep");
      // Bit 1 drops; after four edges its count has reached 2.
      drive_and_check(7'h7D, 4, "areset_count");
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({sw_clean, rise, fall, changed, settled} !== {7'h00, 7'h00, 7'h00, 1'b0, 1'b1}) begin
         n_fails++;
         $display("FAIL areset_immediate: got %h/%h/%h/%b/%b want 00/00/00/0/1",
                  sw_clean, rise, fall, changed, settled);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_and_check(7'h7D, 8, "areset_release");
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      v = sw_raw;
      for (int k = 0; k < 250; k++) begin
         v = v ^ W'($urandom_range(0, 127) & $urandom_range(0, 127));
         sw_raw = v;
         for (int e = 0; e < int'($urandom_range(1, 7)); e++) begin
            tick();
            n_checks++;
            if ({sw_clean, rise, fall, changed, settled} !==
                {m_clean, m_rise, m_fall, m_changed, m_settled} || (rise & fall) !== 7'h00) begin
               n_fails++;
               $display("FAIL random k%0d: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", k,
                        sw_clean, rise, fall, changed, settled,
                        m_clean, m_rise, m_fall, m_changed, m_settled);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      sw_raw   = '0;
      model_reset();
      test_reset();
      test_clean_step();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
